// File: rtl/jpeg_byte_packer.sv
// JPEG output stage: buffers stuffed 32-bit entropy words in a FIFO and serialises them MSB-first
// onto an 8-bit valid/ready stream, padding the last partial byte with 1s and optionally adding EOI.
module jpeg_byte_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter bit ADD_EOI    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic [4:0]  in_bit_count,
  input  logic        in_last,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        frame_done,
  output logic [23:0] frame_bytes,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    DATA   = 3'd2,
    EOI_FF = 3'd3,
    EOI_D9 = 3'd4
  } state_t;

  function automatic logic [23:0] sat_inc(input logic [23:0] v);
    if (v == 24'hFF_FFFF) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 24'd1;
    end
  endfunction

  logic [35:0]  mem_r [FIFO_DEPTH];
  logic [AW:0]  wr_ptr_r, rd_ptr_r;
  logic         empty_s, full_s, push_s, pop_s;
  logic [35:0]  wr_word_s, head_s;
  logic [2:0]   nbytes_s;
  logic         head_last_s, peek_s, fin_tlast_s, hs_s;
  logic [2:0]   head_nb_s;
  logic [31:0]  head_data_s;

  state_t       state_r, state_nx_s;
  logic [31:0]  shift_r, shift_nx_s;
  logic [2:0]   rem_r, rem_nx_s;
  logic         last_r, last_nx_s;
  logic         absorb_r, absorb_nx_s;
  logic [23:0]  cnt_r, cnt_nx_s;
  logic [7:0]   tdata_r, tdata_nx_s;
  logic         tvalid_r, tvalid_nx_s;
  logic         tlast_r, tlast_nx_s;
  logic         done_r, done_nx_s;
  logic [23:0]  fbytes_r, fbytes_nx_s;
  logic         overflow_r;

  assign empty_s     = (wr_ptr_r == rd_ptr_r);
  assign full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign push_s      = in_valid && (!full_s || pop_s);
  assign head_s      = mem_r[rd_ptr_r[AW-1:0]];
  assign head_last_s = head_s[35];
  assign head_nb_s   = head_s[34:32];
  assign head_data_s = head_s[31:0];
  assign hs_s        = tvalid_r && m_tready;
  // An empty final word already queued lets the preceding data byte carry tlast when there is no EOI.
  // If it arrives after that byte is presented, the frame ends without tlast but frame_done still pulses.
  assign peek_s      = !empty_s && head_last_s && (head_nb_s == 3'd0);
  assign fin_tlast_s = (ADD_EOI == 1'b0) && (last_r || peek_s);

  // Word formatting: byte count and 1-padding of the final partial byte
  always_comb begin
    nbytes_s  = 3'd4;
    wr_word_s = {in_last, 3'd4, in_data};
    if (in_last) begin
      nbytes_s  = {1'b0, in_bit_count[4:3]} + {2'b00, |in_bit_count[2:0]};
      wr_word_s = {1'b1, nbytes_s, in_data | (32'hFFFF_FFFF >> in_bit_count)};
    end else begin
      nbytes_s  = 3'd4;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_word_s;
    end
  end

  // FIFO pointers and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      if (in_valid && full_s && !pop_s) overflow_r <= 1'b1;
    end
  end

  // Serialiser next-state and registered-output logic
  always_comb begin
    state_nx_s  = state_r;
    shift_nx_s  = shift_r;
    rem_nx_s    = rem_r;
    last_nx_s   = last_r;
    absorb_nx_s = absorb_r;
    cnt_nx_s    = cnt_r;
    tdata_nx_s  = tdata_r;
    tvalid_nx_s = tvalid_r;
    tlast_nx_s  = tlast_r;
    done_nx_s   = 1'b0;
    fbytes_nx_s = fbytes_r;
    pop_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s      = 1'b1;
          shift_nx_s = head_data_s;
          rem_nx_s   = head_nb_s;
          last_nx_s  = head_last_s;
          state_nx_s = LOAD;
        end else begin
          state_nx_s = IDLE;
        end
      end
      LOAD: begin
        if (rem_r != 3'd0) begin
          state_nx_s  = DATA;
          tdata_nx_s  = shift_r[31:24];
          tvalid_nx_s = 1'b1;
          tlast_nx_s  = (rem_r == 3'd1) && fin_tlast_s;
          absorb_nx_s = (rem_r == 3'd1) && (ADD_EOI == 1'b0) && !last_r && peek_s;
        end else if (last_r && ADD_EOI) begin
          state_nx_s  = EOI_FF;
          tdata_nx_s  = 8'hFF;
          tvalid_nx_s = 1'b1;
          tlast_nx_s  = 1'b0;
        end else begin
          state_nx_s = IDLE;
          if (last_r) begin
            done_nx_s   = 1'b1;
            fbytes_nx_s = cnt_r;
            cnt_nx_s    = 24'd0;
          end else begin
            cnt_nx_s    = cnt_r;
          end
        end
      end
      DATA: begin
        if (hs_s) begin
          cnt_nx_s = sat_inc(cnt_r);
          if (rem_r > 3'd1) begin
            shift_nx_s  = {shift_r[23:0], 8'h00};
            rem_nx_s    = rem_r - 3'd1;
            tdata_nx_s  = shift_r[23:16];
            tlast_nx_s  = (rem_r == 3'd2) && fin_tlast_s;
            absorb_nx_s = (rem_r == 3'd2) && (ADD_EOI == 1'b0) && !last_r && peek_s;
          end else if (last_r || absorb_r) begin
            if (ADD_EOI) begin
              state_nx_s = EOI_FF;
              tdata_nx_s = 8'hFF;
              tlast_nx_s = 1'b0;
            end else begin
              pop_s       = absorb_r;
              absorb_nx_s = 1'b0;
              tvalid_nx_s = 1'b0;
              tlast_nx_s  = 1'b0;
              done_nx_s   = 1'b1;
              fbytes_nx_s = sat_inc(cnt_r);
              cnt_nx_s    = 24'd0;
              state_nx_s  = IDLE;
            end
          end else begin
            tvalid_nx_s = 1'b0;
            tlast_nx_s  = 1'b0;
            if (!empty_s) begin
              pop_s      = 1'b1;
              shift_nx_s = head_data_s;
              rem_nx_s   = head_nb_s;
              last_nx_s  = head_last_s;
              state_nx_s = LOAD;
            end else begin
              state_nx_s = IDLE;
            end
          end
        end else begin
          state_nx_s = DATA;
        end
      end
      EOI_FF: begin
        if (hs_s) begin
          cnt_nx_s   = sat_inc(cnt_r);
          tdata_nx_s = 8'hD9;
          tlast_nx_s = 1'b1;
          state_nx_s = EOI_D9;
        end else begin
          state_nx_s = EOI_FF;
        end
      end
      EOI_D9: begin
        if (hs_s) begin
          tvalid_nx_s = 1'b0;
          tlast_nx_s  = 1'b0;
          done_nx_s   = 1'b1;
          fbytes_nx_s = sat_inc(cnt_r);
          cnt_nx_s    = 24'd0;
          state_nx_s  = IDLE;
        end else begin
          state_nx_s = EOI_D9;
        end
      end
      default: begin
        state_nx_s  = IDLE;
        tvalid_nx_s = 1'b0;
        tlast_nx_s  = 1'b0;
      end
    endcase
  end

  // Serialiser state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      shift_r  <= 32'd0;
      rem_r    <= 3'd0;
      last_r   <= 1'b0;
      absorb_r <= 1'b0;
      cnt_r    <= 24'd0;
      tdata_r  <= 8'd0;
      tvalid_r <= 1'b0;
      tlast_r  <= 1'b0;
      done_r   <= 1'b0;
      fbytes_r <= 24'd0;
    end else begin
      state_r  <= state_nx_s;
      shift_r  <= shift_nx_s;
      rem_r    <= rem_nx_s;
      last_r   <= last_nx_s;
      absorb_r <= absorb_nx_s;
      cnt_r    <= cnt_nx_s;
      tdata_r  <= tdata_nx_s;
      tvalid_r <= tvalid_nx_s;
      tlast_r  <= tlast_nx_s;
      done_r   <= done_nx_s;
      fbytes_r <= fbytes_nx_s;
    end
  end

  assign m_tdata     = tdata_r;
  assign m_tvalid    = tvalid_r;
  assign m_tlast     = tlast_r;
  assign frame_done  = done_r;
  assign frame_bytes = fbytes_r;
  assign overflow    = overflow_r;

endmodule
